// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the execute stage of the MIPS pipeline.
//
// Holds the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run as
// multi-cycle operations (busy for MULT_CYCLES / DIV_CYCLES cycles), with the
// result computed from the operands captured at the start edge and written to
// HI/LO on the final busy edge. MTHI/MTLO update HI/LO at the start edge.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high
//   start  in   1   E-stage holds a multiply/divide-class op
//   op     in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   a      in  32   rs operand
//   b      in  32   rt operand
//   busy   out  1   multi-cycle operation in progress (registered)
//   hi     out 32   architectural HI (registered)
//   lo     out 32   architectural LO (registered)
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    // -----------------------------------------------------------------------
    // Result datapath, evaluated on the live operands and captured at the
    // start edge only.
    // -----------------------------------------------------------------------
    logic        is_signed;
    logic        is_mul;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] mag_a, mag_b, div_den;
    logic [31:0] quot_mag, rem_mag, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_mul    = (op == OP_MULT) || (op == OP_MULTU);

        // Extending to 64 bits and keeping the low 64 bits of the product
        // yields the correct two's-complement result for both signednesses.
        mul_a   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        mul_b   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product = mul_a * mul_b;

        // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps
        // naturally (magnitude 0x80000000, negated back to 0x80000000).
        mag_a    = (is_signed && a[31]) ? (~a + 32'd1) : a;
        mag_b    = (is_signed && b[31]) ? (~b + 32'd1) : b;
        // Substitute 1 for a zero divisor; the result is discarded anyway.
        div_den  = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quot_mag = mag_a / div_den;
        rem_mag  = mag_a % div_den;
        quot     = (is_signed && (a[31] ^ b[31])) ? (~quot_mag + 32'd1) : quot_mag;
        rem      = (is_signed && a[31]) ? (~rem_mag + 32'd1) : rem_mag;

        res_hi = is_mul ? product[63:32] : rem;
        res_lo = is_mul ? product[31:0]  : quot;
        // A divide by zero runs the full period but leaves HI/LO untouched.
        res_wr = is_mul || (b != 32'd0);
    end

    // -----------------------------------------------------------------------
    // Control FSM and architectural state.
    // -----------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                count   <= is_mul ? MULT_LOAD : DIV_LOAD;
                                pend_hi <= res_hi;
                                pend_lo <= res_lo;
                                pend_wr <= res_wr;
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is ignored here: HI/LO only change at completion.
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        pend_wr <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit. Directed cases from the
// block's test plan, a randomized op stream against a behavioural HI/LO
// model, then a reset-during-divide run.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors;
    int miscompares;

    logic [31:0] model_hi, model_lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // HI/LO reference written from the architectural rules with 64-bit
    // integer arithmetic (truncating division, remainder follows dividend).
    task automatic model_exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] p, q, r;
        bit          sgn;
        sgn = (o == 3'd0) || (o == 3'd2);
        sx  = sgn ? longint'($signed(x)) : longint'({32'd0, x});
        sy  = sgn ? longint'($signed(y)) : longint'({32'd0, y});
        case (o)
            3'd0, 3'd1: begin
                p = sx * sy;
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (y != 32'd0) begin
                    q = sx / sy;
                    r = sx % sy;
                    model_lo = q[31:0];
                    model_hi = r[31:0];
                end
            end
            3'd4: model_hi = x;
            3'd5: model_lo = x;
            default: ;
        endcase
    endtask

    // Issue one op from IDLE and follow it to completion. With inject set,
    // MTHI/MTLO are presented while busy and must be ignored.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit inject);
        int          n, exp_len;
        bit          held;
        logic [31:0] oh, ol;
        oh = model_hi;
        ol = model_lo;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        model_exec(o, x, y);
        if (o >= 3'd4) begin
            chk("nomd_busy", {31'd0, busy}, 32'd0);
            chk("nomd_hi", hi, model_hi);
            chk("nomd_lo", lo, model_lo);
            return;
        end
        exp_len = (o < 3'd2) ? MC : DC;
        n = 0;
        held = 1'b1;
        while (busy && n < 200) begin
            if (hi !== oh || lo !== ol) held = 1'b0;
            if (inject && (n == 1 || n == 2)) begin
                start = 1'b1;
                op    = (n == 1) ? 3'd5 : 3'd4;
                a     = $urandom;
            end
            tick();
            start = 1'b0;
            a = $urandom; b = $urandom;
            n++;
        end
        chk("busy_len", n, exp_len);
        chk("hold_old", {31'd0, held}, 32'd1);
        chk("res_hi", hi, model_hi);
        chk("res_lo", lo, model_lo);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vectors = 0;
        miscompares = 0;
        model_hi = '0;
        model_lo = '0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        tick();
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();

        // Directed arithmetic cases.
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        do_op(3'd3, 32'h8000_0000, 32'd3, 1'b0);
        chk("divu_lo", lo, 32'h2AAA_AAAA);
        chk("divu_hi", hi, 32'h0000_0002);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        // MTHI then MTLO on consecutive cycles.
        do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        do_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        chk("mt_hi", hi, 32'h1234_5678);
        chk("mt_lo", lo, 32'h9ABC_DEF0);

        // Divide by zero leaves HI/LO as they were.
        do_op(3'd4, 32'h11, 32'd0, 1'b0);
        do_op(3'd5, 32'h22, 32'd0, 1'b0);
        do_op(3'd2, 32'h1234, 32'd0, 1'b0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        do_op(3'd3, 32'hFFFF_0000, 32'd0, 1'b0);

        // MTLO/MTHI presented while busy are ignored.
        do_op(3'd0, 32'h0001_0003, 32'h7FFF_0005, 1'b1);
        do_op(3'd2, 32'h7654_3210, 32'hFFFF_FF85, 1'b1);

        // No-op encodings.
        do_op(3'd6, 32'hAAAA_AAAA, 32'd0, 1'b0);
        do_op(3'd7, 32'h5555_5555, 32'd0, 1'b0);

        // Randomized op stream.
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), ($urandom_range(0, 3) == 0));
        end

        // Reset during busy cycle 3 of a divide aborts it.
        do_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b0);
        do_op(3'd5, 32'hCAFE_0002, 32'd0, 1'b0);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (DC + 3) tick();
        chk("abort_busy_late", {31'd0, busy}, 32'd0);
        chk("abort_hi_late", hi, 32'd0);
        chk("abort_lo_late", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
